// File: rtl/img_pass_ctrl_pkg.sv
// ============================================================================
// Module : img_ctrl_pkg
// Brief  : Shared types and constants for the image pass controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package img_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_COPY   = 2'd0;
    localparam logic [1:0] OP_INV    = 2'd1;
    localparam logic [1:0] OP_THRESH = 2'd2;
    localparam logic [1:0] OP_BRIGHT = 2'd3;

    // Value of src_bank naming which bank is currently the read source.
    localparam logic BANK1_SRC = 1'b0;
    localparam logic BANK2_SRC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/img_pass_ctrl_if.sv
// ============================================================================
// Module : img_pass_ctrl_if
// Brief  : Request, BRAM control and status bundle of the pass controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface img_pass_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [1:0]        op;
    logic              ena;
    logic              enb;
    logic              wea1;
    logic              wea2;
    logic [ADDR_W-1:0] addra;
    logic [ADDR_W-1:0] addrb;
    logic [1:0]        sel;
    logic              src_bank;
    logic              busy;
    logic              complete;

    modport master (
        output start, op,
        input  ena, enb, wea1, wea2, addra, addrb, sel, src_bank, busy, complete
    );

    modport slave (
        input  start, op,
        output ena, enb, wea1, wea2, addra, addrb, sel, src_bank, busy, complete
    );
endinterface

`default_nettype wire

// File: rtl/img_pass_ctrl_valid_delay.sv
// ============================================================================
// Module : valid_delay
// Brief  : DEPTH-stage shift register for 1-bit valid/tag strobes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module valid_delay #(
    parameter int DEPTH = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_strobe,
    output logic      o_strobe
);
    logic [DEPTH-1:0] r_sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sr <= '0;
                else     r_sr <= i_strobe;
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sr <= '0;
                else     r_sr <= {r_sr[DEPTH-2:0], i_strobe};
            end
        end
    endgenerate

    assign o_strobe = r_sr[DEPTH-1];
endmodule

`default_nettype wire

// File: rtl/img_pass_ctrl.sv
// ============================================================================
// Module : img_pass_ctrl
// Brief  : Streams one frame from the source BRAM bank through the pixel-op
//          datapath into the other bank, then swaps the banks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module img_pass_ctrl
    import img_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int IMG_PIXELS = 65536,
    parameter int PIPE_LAT   = 3
) (
    input wire logic        clk,
    input wire logic        rst,
    img_pass_ctrl_if.slave  bus
);
    localparam logic [ADDR_W-1:0] c_last_pix = ADDR_W'(IMG_PIXELS - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic              w_start;
    logic              w_rd_issue;
    logic              w_wr_strobe;

    logic              r_ena;
    logic              r_enb;
    logic              r_wea1;
    logic              r_wea2;
    logic [ADDR_W-1:0] r_addra;
    logic [ADDR_W-1:0] r_addrb;
    logic [1:0]        r_sel;
    logic              r_src_bank;
    logic              r_busy;
    logic              r_complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // The last write is visible on the ports while still in DRAIN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = READ;
            READ:    if (r_rd_cnt == c_last_pix) w_next = DRAIN;
            DRAIN:   if (r_enb && (r_addrb == c_last_pix)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_rd_issue = 1'b0;
        case (r_state)
            IDLE:    w_start    = bus.start;
            READ:    w_rd_issue = 1'b1;
            default: ;
        endcase
    end

    valid_delay #(
        .DEPTH    (PIPE_LAT)
    ) u_valid_delay (
        .clk      (clk),
        .rst      (rst),
        .i_strobe (w_rd_issue),
        .o_strobe (w_wr_strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ena      <= 1'b0;
            r_enb      <= 1'b0;
            r_wea1     <= 1'b0;
            r_wea2     <= 1'b0;
            r_addra    <= '0;
            r_addrb    <= '0;
            r_rd_cnt   <= '0;
            r_sel      <= OP_COPY;
            r_src_bank <= BANK1_SRC;
            r_busy     <= 1'b0;
            r_complete <= 1'b0;
        end else begin
            r_ena  <= w_rd_issue;
            r_enb  <= w_wr_strobe;
            r_wea1 <= w_wr_strobe & (r_src_bank == BANK2_SRC);
            r_wea2 <= w_wr_strobe & (r_src_bank == BANK1_SRC);

            if (w_start) begin
                r_sel    <= bus.op;
                r_addra  <= '0;
                r_rd_cnt <= '0;
            end else if (w_rd_issue) begin
                r_addra  <= r_rd_cnt;
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            if (w_start)    r_addrb <= '0;
            else if (r_enb) r_addrb <= r_addrb + 1'b1;

            r_busy     <= (w_next != IDLE);
            r_complete <= (w_next == DONE);
            if (w_next == DONE) r_src_bank <= ~r_src_bank;
        end
    end

    assign bus.ena      = r_ena;
    assign bus.enb      = r_enb;
    assign bus.wea1     = r_wea1;
    assign bus.wea2     = r_wea2;
    assign bus.addra    = r_addra;
    assign bus.addrb    = r_addrb;
    assign bus.sel      = r_sel;
    assign bus.src_bank = r_src_bank;
    assign bus.busy     = r_busy;
    assign bus.complete = r_complete;
endmodule

`default_nettype wire

// File: doc/img_pass_ctrl.md
Name: img_pass_ctrl

Overview:
- Sequences one image-processing pass over the two dual-port pixel BRAMs.
- Streams every pixel from the source bank through the selected pixel-op datapath, and writes the results to the other bank at the same address.
- Ping-pongs the source and destination banks after each completed pass, so successive passes chain without copying.
- Drives the BRAM enables and write enables and the datapath op select; reports completion with a one-cycle pulse.

Parameters:
- ADDR_W, 16, width of the pixel address buses.
- IMG_PIXELS, 65536, pixels per frame. Range 1..2^ADDR_W.
- PIPE_LAT, 3, cycles from addra presented to result valid at the write port. Covers BRAM read plus datapath. Must be >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pass request. Sampled only in IDLE.
- op  in  2  pixel operation for the pass (0 copy, 1 invert, 2 threshold, 3 brighten). Latched on accepted start.
- ena  out  1  read-port enable of the source bank.
- enb  out  1  write-port enable of the destination bank.
- wea1  out  1  write enable, bank 1.
- wea2  out  1  write enable, bank 2.
- addra  out  ADDR_W  read address.
- addrb  out  ADDR_W  write address.
- sel  out  2  op select to the datapath mux. Equals the latched op.
- src_bank  out  1  0: bank1 is source and bank2 is destination; 1: the reverse.
- busy  out  1  high from READ through DONE.
- complete  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset values: state=IDLE; ena, enb, wea1, wea2, busy, complete = 0; addra, addrb = 0; sel=0; src_bank=0. Reset mid-pass aborts immediately, with no further writes.
- All outputs are registered.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: when start=1, latch op into sel and go to READ. While busy, start is ignored and is not queued.
- READ: lasts exactly IMG_PIXELS cycles. ena=1; addra = 0,1,...,IMG_PIXELS-1, one address per cycle. After the last address, go to DRAIN; addra holds its final value and ena drops.
- Valid delay line, PIPE_LAT stages: input is the read-issue strobe.
  - Its output drives enb and the destination write enable: wea2 when src_bank=0, wea1 when src_bank=1.
  - The source-bank write enable stays 0 for the whole pass.
  - addrb is a write counter that increments after each write, so write k lands at addrb=k.
- Timing, with start accepted at edge t:
  - Read k is issued at cycle t+1+k.
  - Write k occurs at cycle t+1+k+PIPE_LAT.
- DRAIN: exits after the last write, i.e. when the write counter wraps past IMG_PIXELS-1 and the delay line is empty. Then go to DONE.
- DONE: one cycle. complete=1; src_bank toggles on the edge entering DONE; return to IDLE.
- Start-to-complete latency is IMG_PIXELS+PIPE_LAT+1 cycles. complete is high exactly once per pass.
- Counters reset to 0 at every pass start, with no wrap hazards.
- IMG_PIXELS=1: READ lasts one cycle and the sequence is otherwise identical.
- sel is stable for the whole pass; changes on op are ignored while busy.
- start asserted in the same cycle complete is high is ignored (the FSM is in DONE). It is accepted on the following cycle.

Decomposition:
- Package img_ctrl_pkg holds:
  - the state enum (IDLE, READ, DRAIN, DONE);
  - the op-code constants OP_COPY, OP_INV, OP_THRESH, OP_BRIGHT;
  - the bank-index constants.
- One sub-module, valid_delay: a PIPE_LAT-deep shift register of 1-bit strobes with asynchronous active-high reset. It is reusable for datapath tag alignment.

Test Plan (bench overrides IMG_PIXELS=16, PIPE_LAT=3):
- Reset, then start pulse with op=1:
  - sel=1, ena high for 16 cycles with addra 0..15;
  - wea2 and enb high for 16 cycles with addrb 0..15, first write 3 cycles after the first read;
  - wea1 never asserted;
  - complete pulses 20 cycles after start; src_bank then reads 1.
- Second pass with op=2: wea1 carries the writes instead of wea2; complete pulses after 20 cycles; src_bank returns to 0.
- start pulsed at cycles 5 and 10 of a pass, with op changed to 3 mid-pass: no restart, sel stays at its latched value, exactly one complete.
- rst asserted at read cycle 8: all outputs reach reset values asynchronously. No writes after reset; src_bank=0; a new start then runs a full clean pass.
- start held high continuously: passes run back-to-back, with one IDLE cycle between complete and the next READ; src_bank alternates 0,1,0.
- Rebuild with IMG_PIXELS=1, PIPE_LAT=1: one read at addra 0, one write at addrb 0 one cycle later, complete 3 cycles after start.
